// File: rtl/gpr_mp_file.sv
// gpr_mp_file: multi-port general-purpose register file.
// NUM_READ combinational read ports with per-byte write-through bypass,
// NUM_WRITE byte-enabled write ports, a per-register busy scoreboard, and a
// post-reset clearing sweep so the storage array needs no parallel reset.
module gpr_mp_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 4,
    parameter int NUM_WRITE  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             ready,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_READ-1:0]              rd_busy,
    input  logic [NUM_WRITE-1:0]             wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WRITE*(DATA_WIDTH/8)-1:0] wr_be,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
    input  logic [NUM_WRITE-1:0]             wr_clr,
    input  logic                             sb_set_en,
    input  logic [ADDR_WIDTH-1:0]            sb_set_addr,
    input  logic                             flush
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;

    logic                    run;
    logic [ADDR_WIDTH-1:0]   wa     [NUM_WRITE];
    logic [DATA_WIDTH-1:0]   wd     [NUM_WRITE];
    logic [BYTES-1:0]        wbe    [NUM_WRITE];
    logic [NUM_WRITE-1:0]    wr_act;   // write lands in the array / bypass
    logic [NUM_WRITE-1:0]    clr_act;  // write also releases its busy bit

    assign run   = (state_q == ST_RUN);
    assign ready = ready_q;

    // Split the flat write-port buses into per-port views
    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wport
        assign wa[k]      = wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[k]      = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign wbe[k]     = wr_be[k*BYTES +: BYTES];
        assign wr_act[k]  = run && wr_en[k] && (wa[k] != '0);
        assign clr_act[k] = run && wr_en[k] && wr_clr[k];
    end

    // Sweep/run state machine; ready rises on the edge that clears the last entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Storage array: zeroed by the sweep, then byte writes with the highest port winning
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_INIT) begin
            mem_q[idx_q] <= '0;
        end else if (!reset && run) begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_act[k] && wbe[k][b]) begin
                        mem_q[wa[k]][8*b +: 8] <= wd[k][8*b +: 8];
                    end
                end
            end
        end
    end

    // Scoreboard next state: flush beats set, set beats clear
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (flush) begin
                    busy_d[a] = 1'b0;
                end else if (sb_set_en && sb_set_addr == ADDR_WIDTH'(a)) begin
                    busy_d[a] = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_WRITE; k++) begin
                        if (clr_act[k] && wa[k] == ADDR_WIDTH'(a)) begin
                            busy_d[a] = 1'b0;
                        end
                    end
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: array data overlaid by same-cycle writes, busy with clear bypass
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] word;
        logic                  bz;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        word    = '0;
        bz      = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra   = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            word = mem_q[ra];
            bz   = busy_q[ra];
            for (int k = 0; k < NUM_WRITE; k++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_act[k] && wa[k] == ra && wbe[k][b]) begin
                        word[8*b +: 8] = wd[k][8*b +: 8];
                    end
                end
                if (clr_act[k] && wa[k] == ra) begin
                    bz = 1'b0;
                end
            end
            if (!run || ra == '0) begin
                word = '0;
                bz   = 1'b0;
            end
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = word;
            rd_busy[p] = bz;
        end
    end

endmodule

// File: tb/tb_gpr_mp_file.sv
// Scoreboard bench for gpr_mp_file: a stimulus process computes expected read
// results from a behavioural model and queues them; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_gpr_mp_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;
    localparam int BY    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              ready;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*BY-1:0]  wr_be;
    logic [NW*DW-1:0]  wr_data;
    logic [NW-1:0]     wr_clr;
    logic              sb_set_en;
    logic [AW-1:0]     sb_set_addr;
    logic              flush;

    always #5 clk = ~clk;

    gpr_mp_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_clr(wr_clr), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .flush(flush)
    );

    typedef struct packed {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
        logic             rdy;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model state
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy = '0;
    bit               m_init = 1'b1;
    int               m_cnt = 0;
    bit               m_ready = 1'b0;

    function automatic int waddr(int k);
        return int'(wr_addr[k*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_read(int a);
        logic [DW-1:0] v;
        if (m_init || a == 0) return '0;
        v = m_mem[a];
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && waddr(k) == a)
                for (int b = 0; b < BY; b++)
                    if (wr_be[k*BY + b]) v[8*b +: 8] = wr_data[k*DW + 8*b +: 8];
        return v;
    endfunction

    function automatic logic exp_busy(int a);
        logic bz;
        if (m_init || a == 0) return 1'b0;
        bz = m_busy[a];
        for (int k = 0; k < NW; k++)
            if (wr_en[k] && wr_clr[k] && waddr(k) == a) bz = 1'b0;
        return bz;
    endfunction

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        logic [DEPTH-1:0] nb;
        if (reset) begin
            m_init = 1'b1; m_cnt = 0; m_busy = '0; m_ready = 1'b0;
        end else if (m_init) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin m_init = 1'b0; m_ready = 1'b1; end
            m_cnt++;
        end else begin
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && waddr(k) != 0)
                    for (int b = 0; b < BY; b++)
                        if (wr_be[k*BY + b]) m_mem[waddr(k)][8*b +: 8] = wr_data[k*DW + 8*b +: 8];
            nb = m_busy;
            for (int a = 1; a < DEPTH; a++) begin
                bit clr_hit;
                clr_hit = 1'b0;
                for (int k = 0; k < NW; k++)
                    if (wr_en[k] && wr_clr[k] && waddr(k) == a) clr_hit = 1'b1;
                if (flush) nb[a] = 1'b0;
                else if (sb_set_en && int'(sb_set_addr) == a) nb[a] = 1'b1;
                else if (clr_hit) nb[a] = 1'b0;
            end
            nb[0] = 1'b0;
            m_busy = nb;
        end
    endtask

    // Queue the expectation for the current inputs, then cross one edge
    task automatic step();
        exp_t e;
        for (int p = 0; p < NR; p++) begin
            e.data[p*DW +: DW] = exp_read(int'(rd_addr[p*AW +: AW]));
            e.busy[p]          = exp_busy(int'(rd_addr[p*AW +: AW]));
        end
        e.rdy = m_ready;
        sb_q.push_back(e);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(int n);
        repeat (n) step();
    endtask

    task automatic idle();
        reset = 1'b0; wr_en = '0; wr_be = '0; wr_clr = '0;
        sb_set_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_wr(int k, int a, logic [BY-1:0] be, logic [DW-1:0] d, bit clr);
        wr_en[k]              = 1'b1;
        wr_addr[k*AW +: AW]   = AW'(a);
        wr_be[k*BY +: BY]     = be;
        wr_data[k*DW +: DW]   = d;
        wr_clr[k]             = clr;
    endtask

    task automatic set_sb(int a);
        sb_set_en   = 1'b1;
        sb_set_addr = AW'(a);
    endtask

    // Monitor: compare every queued expectation while outputs are stable
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int p = 0; p < NR; p++) begin
                    tests++;
                    if (rd_data[p*DW +: DW] !== e.data[p*DW +: DW]) begin
                        fails++;
                        $display("FAIL rd_data[%0d] addr=%0d got %h expected %h", p,
                                 rd_addr[p*AW +: AW], rd_data[p*DW +: DW], e.data[p*DW +: DW]);
                    end
                end
                tests++;
                if (rd_busy !== e.busy) begin
                    fails++;
                    $display("FAIL rd_busy got %b expected %b", rd_busy, e.busy);
                end
                tests++;
                if (ready !== e.rdy) begin
                    fails++;
                    $display("FAIL ready got %b expected %b", ready, e.rdy);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rd_addr = {5'd9, 5'd7, 5'd5, 5'd3};
        wr_addr = '0; wr_data = '0; sb_set_addr = '0;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();                       // reset state
        reset = 1'b0;
        run_n(34);                    // clearing sweep, ready after 32 edges

        // Preload reg[7], reset, then a write during the sweep must be lost
        set_wr(0, 7, 4'hF, 32'hDEADBEEF, 1'b0); step(); idle(); step();
        reset = 1'b1; step(); reset = 1'b0;
        run_n(3);
        set_wr(1, 7, 4'hF, 32'h12345678, 1'b0); step(); idle();
        run_n(32);

        // Byte enables and same-cycle bypass
        set_wr(0, 3, 4'hF, 32'h11223344, 1'b0); step(); idle();
        set_wr(0, 3, 4'b0101, 32'hAABBCCDD, 1'b0); step(); idle(); step();

        // Same address on both ports
        set_wr(0, 5, 4'hF, 32'h00000001, 1'b0);
        set_wr(1, 5, 4'hF, 32'h00000002, 1'b0); step(); idle(); step();

        // Register zero
        rd_addr[0 +: AW] = '0;
        set_wr(0, 0, 4'hF, 32'hFFFFFFFF, 1'b1);
        set_wr(1, 0, 4'hF, 32'hFFFFFFFF, 1'b0);
        set_sb(0); step(); idle(); step();
        rd_addr[0 +: AW] = 5'd3;

        // Scoreboard on reg 9
        set_sb(9); step(); idle(); step();
        set_wr(0, 9, 4'hF, 32'h00000099, 1'b1); step(); idle(); step();
        set_sb(9); set_wr(1, 9, 4'hF, 32'h00000077, 1'b1); step(); idle(); step();
        set_sb(9); flush = 1'b1; step(); idle(); step();

        // Reset in the middle of the sweep
        reset = 1'b1; step(); reset = 1'b0;
        run_n(10);
        reset = 1'b1; step(); reset = 1'b0;
        run_n(34);

        // Randomized traffic over a small address range to force collisions
        repeat (800) begin
            reset       = ($urandom_range(0, 299) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            sb_set_en   = ($urandom_range(0, 3) == 0);
            sb_set_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NW; k++) begin
                wr_en[k]            = 1'($urandom_range(0, 1));
                wr_clr[k]           = 1'($urandom_range(0, 1));
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
                wr_be[k*BY +: BY]   = BY'($urandom);
                wr_data[k*DW +: DW] = $urandom;
            end
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            step();
        end
        idle();
        step();

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
